// File: rtl/rand_u8_pkg.sv
// rtl/rand_u8_pkg.sv - shared types and constants for the 8-lane random byte controller
package rand_u8_pkg;

  localparam int LFSR_W = 23;
  localparam int LANES  = 8;
  localparam int LANE_W = $clog2(LANES);
  localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 23'd1;

  typedef enum logic [1:0] {
    WARM = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_e;

  // Bits needed for a down-counter that starts at n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rand_u8_seed_ctrl_if.sv
// rtl/rand_u8_seed_ctrl_if.sv - host seed stream and consumer byte stream bundle
interface rand_u8_seed_ctrl_if;
  import rand_u8_pkg::*;

  logic              seed_valid;
  logic              seed_ready;
  logic [LFSR_W-1:0] seed_data;
  logic              rnd_valid;
  logic              rnd_ready;
  logic [7:0]        rnd_data;

  modport master (
    output seed_valid, seed_data, rnd_ready,
    input  seed_ready, rnd_valid, rnd_data
  );

  modport slave (
    input  seed_valid, seed_data, rnd_ready,
    output seed_ready, rnd_valid, rnd_data
  );

endinterface

// File: rtl/rand_u8_hold.sv
// rtl/rand_u8_hold.sv - byte holding register with decimation counter, sample and flush control
module rand_u8_hold
  import rand_u8_pkg::*;
#(
  parameter int P_DECIM = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       flush,
  input  logic [7:0] ru,
  input  logic       rnd_ready,
  output logic       rnd_valid,
  output logic [7:0] rnd_data
);

  localparam int DEC_W = cnt_w(P_DECIM);
  localparam logic [DEC_W-1:0] DEC_RELOAD = DEC_W'(P_DECIM - 1);

  logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
  logic             rnd_valid_q, rnd_valid_d;
  logic [7:0]       rnd_data_q, rnd_data_d;
  logic             sample;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_cnt_q   <= '0;
      rnd_valid_q <= 1'b0;
      rnd_data_q  <= '0;
    end else begin
      dec_cnt_q   <= dec_cnt_d;
      rnd_valid_q <= rnd_valid_d;
      rnd_data_q  <= rnd_data_d;
    end
  end

  // Flush outranks sampling so a reseed request never lets a new byte through.
  always_comb begin
    sample      = run && !flush && (dec_cnt_q == '0) && (!rnd_valid_q || rnd_ready);
    dec_cnt_d   = dec_cnt_q;
    rnd_valid_d = rnd_valid_q;
    rnd_data_d  = rnd_data_q;
    if (flush) begin
      dec_cnt_d   = '0;
      rnd_valid_d = 1'b0;
      rnd_data_d  = '0;
    end else if (sample) begin
      dec_cnt_d   = DEC_RELOAD;
      rnd_valid_d = 1'b1;
      rnd_data_d  = ru;
    end else begin
      if (dec_cnt_q != '0) dec_cnt_d = dec_cnt_q - 1'b1;
      if (rnd_valid_q && rnd_ready) rnd_valid_d = 1'b0;
    end
  end

  assign rnd_valid = rnd_valid_q;
  assign rnd_data  = rnd_data_q;

endmodule

// File: rtl/rand_u8_seed_ctrl.sv
// rtl/rand_u8_seed_ctrl.sv - seed loader, warm-up sequencer and byte server for the LFSR bank
module rand_u8_seed_ctrl
  import rand_u8_pkg::*;
#(
  parameter int P_WARMUP = 64,
  parameter int P_DECIM  = 8,
  parameter int P_LANES  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  rand_u8_seed_ctrl_if.slave bus,
  output logic [LFSR_W-1:0]  lfsr_seed,
  output logic [P_LANES-1:0] lfsr_seed_wr,
  input  logic [P_LANES-1:0] ru,
  output logic               busy,
  output logic               seeded
);

  localparam int WARM_W = cnt_w(P_WARMUP);
  localparam logic [WARM_W-1:0] WARM_RELOAD = WARM_W'(P_WARMUP - 1);

  state_e               state_q, state_d;
  logic [WARM_W-1:0]    warm_cnt_q, warm_cnt_d;
  logic [LANE_W-1:0]    lane_idx_q, lane_idx_d;
  logic [LFSR_W-1:0]    seed_q, seed_d;
  logic [P_LANES-1:0]   seed_wr_q, seed_wr_d;
  logic                 seeded_q, seeded_d;
  logic                 accept, last_lane, to_load;

  assign accept    = (state_q == LOAD) && bus.seed_valid;
  assign last_lane = (lane_idx_q == LANE_W'(LANES - 1));
  assign to_load   = (state_q != LOAD) && bus.seed_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= WARM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WARM:    if (bus.seed_valid) state_d = LOAD;
               else if (warm_cnt_q == '0) state_d = RUN;
      RUN:     if (bus.seed_valid) state_d = LOAD;
      LOAD:    if (accept && last_lane) state_d = WARM;
      default: state_d = WARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      warm_cnt_q <= WARM_RELOAD;
      lane_idx_q <= '0;
      seed_q     <= '0;
      seed_wr_q  <= '0;
      seeded_q   <= 1'b0;
    end else begin
      warm_cnt_q <= warm_cnt_d;
      lane_idx_q <= lane_idx_d;
      seed_q     <= seed_d;
      seed_wr_q  <= seed_wr_d;
      seeded_q   <= seeded_d;
    end
  end

  // An all-zero seed would lock a lane up, so it is replaced on the way out.
  always_comb begin
    warm_cnt_d = warm_cnt_q;
    lane_idx_d = lane_idx_q;
    seed_d     = seed_q;
    seed_wr_d  = '0;
    seeded_d   = seeded_q;
    if (state_q == WARM && warm_cnt_q != '0) warm_cnt_d = warm_cnt_q - 1'b1;
    if (accept) begin
      seed_d     = (bus.seed_data == '0) ? ZERO_SEED_SUB : bus.seed_data;
      seed_wr_d  = P_LANES'(1) << lane_idx_q;
      lane_idx_d = lane_idx_q + 1'b1;
      if (last_lane) begin
        seeded_d   = 1'b1;
        warm_cnt_d = WARM_RELOAD;
      end
    end
  end

  always_comb begin
    bus.seed_ready = (state_q == LOAD);
    busy           = (state_q != RUN);
    lfsr_seed      = seed_q;
    lfsr_seed_wr   = seed_wr_q;
    seeded         = seeded_q;
  end

  rand_u8_hold #(.P_DECIM(P_DECIM)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (state_q == RUN),
    .flush     (to_load),
    .ru        (ru),
    .rnd_ready (bus.rnd_ready),
    .rnd_valid (bus.rnd_valid),
    .rnd_data  (bus.rnd_data)
  );

endmodule

// File: tb/tb_rand_u8_seed_ctrl.sv
// tb/tb_rand_u8_seed_ctrl.sv - scoreboard bench for rand_u8_seed_ctrl
module tb_rand_u8_seed_ctrl;
  import rand_u8_pkg::*;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } rnd_exp_t;

  typedef struct {
    logic [7:0]  wr;
    logic [22:0] seed;
    int          gap;
  } seed_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [22:0] lfsr_seed;
  logic [7:0]  lfsr_seed_wr;
  logic [7:0]  ru = 8'h00;
  logic        busy;
  logic        seeded;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  rnd_exp_t  rq[$];
  seed_exp_t sq[$];
  rnd_exp_t  re;
  seed_exp_t se;

  rand_u8_seed_ctrl_if bus();

  rand_u8_seed_ctrl #(.P_WARMUP(64), .P_DECIM(8), .P_LANES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .lfsr_seed    (lfsr_seed),
    .lfsr_seed_wr (lfsr_seed_wr),
    .ru           (ru),
    .busy         (busy),
    .seeded       (seeded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Lane bits are a known function of the cycle so every sampled byte is predictable.
  always begin
    @(posedge clk);
    #1;
    ru = 8'(cyc) ^ 8'h5A;
  end

  function automatic logic [7:0] exp_byte(input int m);
    int t;
    t = m - 1;
    return 8'(t) ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_rnd(input int c);
    rq.push_back('{c, exp_byte(c)});
  endtask

  task automatic expect_seed(input logic [7:0] wr, input logic [22:0] sd, input int gap);
    sq.push_back('{wr, sd, gap});
  endtask

  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_seed(input logic [22:0] d);
    logic hs;
    int   n;
    bus.seed_valid = 1'b1;
    bus.seed_data  = d;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 100) begin
      @(negedge clk);
      hs = bus.seed_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) begin
      n_cmp++;
      n_err++;
      $display("FAIL seed_timeout: got no seed_ready want accept of %0h", d);
    end
  endtask

  // Byte monitor: remembers when each byte was first presented, checks it on handshake.
  logic prev_valid = 1'b0;
  logic prev_hs = 1'b0;
  int   pres_cyc = 0;
  always @(negedge clk) begin
    if (bus.rnd_valid && (!prev_valid || prev_hs)) pres_cyc = cyc;
    if (bus.rnd_valid && bus.rnd_ready) begin
      if (rq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rnd_unexpected: got byte %0h at cyc %0d want none", bus.rnd_data, cyc);
      end else begin
        re = rq.pop_front();
        chk("rnd_present_cyc", pres_cyc, re.cyc);
        chk("rnd_data", {24'h0, bus.rnd_data}, {24'h0, re.data});
      end
    end
    prev_valid = bus.rnd_valid;
    prev_hs    = bus.rnd_valid && bus.rnd_ready;
  end

  // Seed strobe monitor.
  int last_wr_cyc = 0;
  always @(negedge clk) begin
    if (lfsr_seed_wr != 8'h00) begin
      if (sq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL seed_unexpected: got wr %0h seed %0h want none", lfsr_seed_wr, lfsr_seed);
      end else begin
        se = sq.pop_front();
        chk("seed_wr", {24'h0, lfsr_seed_wr}, {24'h0, se.wr});
        chk("seed_val", {9'h0, lfsr_seed}, {9'h0, se.seed});
        if (se.gap != 0) chk("seed_gap", cyc - last_wr_cyc, se.gap);
      end
      last_wr_cyc = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit want finish");
    $fatal(1);
  end

  logic [22:0] seeds2 [8];
  int r;
  int a8;

  initial begin
    seeds2 = '{23'h0, 23'h7FFFFF, 23'h400000, 23'h2AAAAA,
               23'h155555, 23'h000100, 23'h123456, 23'h654321};
    bus.seed_valid = 1'b0;
    bus.seed_data  = '0;
    bus.rnd_ready  = 1'b1;

    go(3);
    chk("rst_busy", busy, 1);
    chk("rst_seeded", seeded, 0);
    chk("rst_seed_ready", bus.seed_ready, 0);
    chk("rst_lfsr_seed", lfsr_seed, 0);
    chk("rst_seed_wr", lfsr_seed_wr, 0);
    chk("rst_rnd_valid", bus.rnd_valid, 0);
    chk("rst_rnd_data", bus.rnd_data, 0);

    // Warm-up then full-rate consumer
    rst_n = 1'b1;
    r = cyc;
    expect_rnd(r + 65);
    expect_rnd(r + 73);
    expect_rnd(r + 81);
    expect_rnd(r + 89);
    go(r + 63);
    chk("busy_warm_last", busy, 1);
    go(r + 64);
    chk("busy_run", busy, 0);

    // Stalled consumer; after release the next byte follows the handshake immediately
    go(r + 92);
    bus.rnd_ready = 1'b0;
    expect_rnd(r + 97);
    expect_rnd(r + 133);
    go(r + 120);
    chk("stall_valid", bus.rnd_valid, 1);
    go(r + 132);
    bus.rnd_ready = 1'b1;
    go(r + 140);
    bus.rnd_ready = 1'b0;

    // Reseed request while byte r+141 is pending: it must be flushed, never delivered
    go(r + 145);
    bus.seed_valid = 1'b1;
    bus.seed_data  = 23'd1;
    for (int i = 0; i < 8; i++) expect_seed(8'(1 << i), 23'(i + 1), (i == 0) ? 0 : 1);
    go(r + 146);
    chk("flush_rnd_valid", bus.rnd_valid, 0);
    chk("load_seed_ready", bus.seed_ready, 1);
    chk("load_busy", busy, 1);
    bus.rnd_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_seed(23'(i + 1));
    bus.seed_valid = 1'b0;
    a8 = cyc;
    chk("seeded_after_load", seeded, 1);
    chk("warm_after_load", busy, 1);
    chk("ready_after_load", bus.seed_ready, 0);
    expect_rnd(a8 + 65);
    expect_rnd(a8 + 73);
    go(a8 + 76);

    // Partial load with a zero seed on lane 3, then reset mid-load
    expect_seed(8'h01, 23'h11, 0);
    expect_seed(8'h02, 23'h22, 1);
    expect_seed(8'h04, 23'h33, 1);
    expect_seed(8'h08, 23'h1, 1);
    send_seed(23'h11);
    send_seed(23'h22);
    send_seed(23'h33);
    send_seed(23'h0);
    bus.seed_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    go(cyc + 3);
    chk("rst2_seeded", seeded, 0);
    chk("rst2_busy", busy, 1);
    chk("rst2_seed_ready", bus.seed_ready, 0);
    chk("rst2_seed_wr", lfsr_seed_wr, 0);

    // Fresh full load restarts at lane 0
    rst_n = 1'b1;
    expect_seed(8'h01, 23'h1, 0);
    for (int i = 1; i < 8; i++) expect_seed(8'(1 << i), seeds2[i], 1);
    for (int i = 0; i < 8; i++) send_seed(seeds2[i]);
    bus.seed_valid = 1'b0;
    a8 = cyc;
    chk("seeded_reload", seeded, 1);
    expect_rnd(a8 + 65);
    go(a8 + 70);

    chk("rnd_queue_drained", rq.size(), 0);
    chk("seed_queue_drained", sq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
